// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB-based branch predictor.
package branch_predictor_pkg;

  // Matches the CPU-wide program counter width.
  localparam int PC_SIZE = 16;

  typedef enum logic [1:0] {
    CNT_SNT = 2'd0,
    CNT_WNT = 2'd1,
    CNT_WT  = 2'd2,
    CNT_ST  = 2'd3
  } cnt_state_e;

  // Tag is kept full PC width so the struct is independent of ENTRIES; unused upper bits stay 0.
  typedef struct packed {
    logic               valid;
    logic [PC_SIZE-1:0] tag;
    logic [PC_SIZE-1:0] target;
    cnt_state_e         cnt;
  } btb_entry_t;

  localparam cnt_state_e CNT_RESET       = CNT_WNT;
  localparam cnt_state_e CNT_ALLOC_JUMP  = CNT_ST;
  localparam cnt_state_e CNT_ALLOC_BR    = CNT_WT;

endpackage

// File: rtl/branch_predictor_if.sv
// Resolved control-flow feedback from execute into the predictor.
interface branch_feedback_ifc;
  import branch_predictor_pkg::*;

  logic               branch;
  logic               jump;
  logic [PC_SIZE-1:0] pc;
  logic [PC_SIZE-1:0] predict_target;
  logic [PC_SIZE-1:0] feedback_target;
  logic               predict_taken;
  logic               feedback_taken;

  modport out (output branch, jump, pc, predict_target, feedback_target, predict_taken, feedback_taken);
  modport in  (input  branch, jump, pc, predict_target, feedback_target, predict_taken, feedback_taken);
  modport master (output branch, jump, pc, predict_target, feedback_target, predict_taken, feedback_taken);
  modport slave  (input  branch, jump, pc, predict_target, feedback_target, predict_taken, feedback_taken);
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next state of a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  cnt_state_e cur,
  input  logic       taken,
  output cnt_state_e nxt
);
  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != CNT_ST) nxt = cnt_state_e'(cur + 2'd1);
    end else begin
      if (cur != CNT_SNT) nxt = cnt_state_e'(cur - 2'd1);
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; zero-latency lookup, update at next edge.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_SIZE-1:0] fetch_pc,
  output logic               predict_taken,
  output logic [PC_SIZE-1:0] predict_target,
  branch_feedback_ifc.in     feedback,
  output logic [15:0]        branch_count,
  output logic [15:0]        mispredict_count
);
  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t table_q [ENTRIES];

  // Lookup; rst masks hits so the reset cycle already looks empty.
  logic [IDX_W-1:0]   f_idx;
  logic [PC_SIZE-1:0] f_tag;
  btb_entry_t         f_ent;
  logic               f_hit;

  always_comb begin
    f_idx          = fetch_pc[IDX_W-1:0];
    f_tag          = fetch_pc >> IDX_W;
    f_ent          = table_q[f_idx];
    f_hit          = f_ent.valid && (f_ent.tag == f_tag) && !rst;
    predict_taken  = f_hit && f_ent.cnt[1];
    predict_target = predict_taken ? f_ent.target : PC_SIZE'(fetch_pc + 1'b1);
  end

  // Update path
  logic [IDX_W-1:0]   u_idx;
  logic [PC_SIZE-1:0] u_tag;
  btb_entry_t         u_cur, u_new;
  logic               u_hit, u_we, fb_valid, mispredict;
  cnt_state_e         cnt_nxt;

  sat_counter2 u_sat (
    .cur   (u_cur.cnt),
    .taken (feedback.feedback_taken),
    .nxt   (cnt_nxt)
  );

  always_comb begin
    fb_valid = feedback.branch || feedback.jump;
    u_idx    = feedback.pc[IDX_W-1:0];
    u_tag    = feedback.pc >> IDX_W;
    u_cur    = table_q[u_idx];
    u_hit    = u_cur.valid && (u_cur.tag == u_tag);
    u_new    = u_cur;
    u_we     = 1'b0;
    if (feedback.jump) begin
      // Jumps win over branch; hit and miss both end as a strong-taken entry.
      u_we  = 1'b1;
      u_new = '{valid: 1'b1, tag: u_tag, target: feedback.feedback_target, cnt: CNT_ALLOC_JUMP};
    end else if (feedback.branch) begin
      if (u_hit) begin
        u_we      = 1'b1;
        u_new.cnt = cnt_nxt;
        if (feedback.feedback_taken) u_new.target = feedback.feedback_target;
      end else if (feedback.feedback_taken) begin
        u_we  = 1'b1;
        u_new = '{valid: 1'b1, tag: u_tag, target: feedback.feedback_target, cnt: CNT_ALLOC_BR};
      end
    end
    mispredict = fb_valid &&
                 ((feedback.predict_taken != feedback.feedback_taken) ||
                  (feedback.predict_taken && feedback.feedback_taken &&
                   (feedback.predict_target != feedback.feedback_target)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_RESET};
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (u_we) table_q[u_idx] <= u_new;
      if (fb_valid && branch_count != 16'hFFFF)     branch_count     <= branch_count + 16'd1;
      if (mispredict && mispredict_count != 16'hFFFF) mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, default 16, number of BTB entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 fetch_pc  input  PC_SIZE  PC being fetched this cycle.
REQ-005 predict_taken  output  1  prediction for fetch_pc.
REQ-006 predict_target  output  PC_SIZE  predicted next PC for fetch_pc.
REQ-007 feedback  branch_feedback_ifc.in  -  resolved control-flow result from execute (branch, jump, pc, predict_target, feedback_target, predict_taken, feedback_taken).
REQ-008 branch_count  output  16  resolved control-flow instructions seen.
REQ-009 mispredict_count  output  16  mispredictions seen.

Function
REQ-010 Table: ENTRIES entries; each holds valid, tag, target (PC_SIZE), and a 2-bit saturating counter (0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T).
REQ-011 Indexing: index = pc[log2(ENTRIES)-1:0]; tag = remaining upper pc bits.
REQ-012 Lookup is combinational from registered table state, zero-cycle latency.
REQ-013 Hit = entry valid and tag match; predict_taken = hit and counter[1].
REQ-014 predict_target = stored target when predict_taken, else fetch_pc + 1 modulo 2^PC_SIZE.
REQ-015 Feedback valid = feedback.branch or feedback.jump; when both are asserted, the update SHALL be treated as a jump.
REQ-016 Hit on jump: counter set to 3, target set to feedback_target.
REQ-017 Hit on branch taken: counter +1, saturating at 3; target set to feedback_target.
REQ-018 Hit on branch not taken: counter -1, saturating at 0; target unchanged.
REQ-019 Miss, jump or branch taken: allocate (overwrite index); valid=1, new tag, target=feedback_target, counter=3 for jump, 2 for branch.
REQ-020 Miss, branch not taken: no table change.
REQ-021 Updates SHALL take effect at the next edge; a same-cycle lookup of the index being updated SHALL see the pre-update entry (no bypass).
REQ-022 Mispredict = feedback valid and (feedback.predict_taken != feedback.feedback_taken, or both taken and feedback.predict_target != feedback.feedback_target).
REQ-023 branch_count SHALL increment on each valid feedback; mispredict_count SHALL increment on each mispredict; both SHALL saturate at 16'hFFFF.
REQ-024 No feedback valid: table and counters SHALL hold.

Reset
REQ-025 On rst: all valid bits 0, all counters 1, tags and targets 0, branch_count 0, mispredict_count 0.
REQ-026 rst SHALL override any same-cycle feedback update.
REQ-027 While rst is high and the cycle after, outputs SHALL reflect the empty table: predict_taken 0, predict_target = fetch_pc + 1.

Structure
REQ-028 A shared package SHALL hold the counter-state enum, the BTB entry struct and the counter reset/allocate constants; PC_SIZE comes from nand_cpu.svh.
REQ-029 One sub-module, sat_counter2: combinational next-state of a 2-bit saturating counter given taken/not-taken; instantiated once on the update path.
REQ-030 Table storage SHALL be flops (arrays of the package struct), not an inferred RAM, to guarantee the same-cycle read of REQ-012.

Verification
REQ-031 After reset, fetch_pc=0x10 -> predict_taken 0, predict_target 0x11; both counts 0.
REQ-032 Branch pc=0x10, taken, target 0x40 (predict_taken 0) -> next cycle fetch_pc=0x10 gives taken, target 0x40; mispredict_count 1.
REQ-033 Same branch not taken twice -> counter 2->1->0; predictions taken then not-taken; fetch_pc=0x10 gives target 0x11 after the second update.
REQ-034 Aliasing (ENTRIES=16): jump pc=0x10 -> 0x40, then jump pc=0x20 -> 0x80 -> pc 0x10 misses (target 0x11); pc 0x20 hits (target 0x80).
REQ-035 Feedback for pc=0x10 and lookup of 0x10 in the same cycle -> lookup returns old prediction; next cycle returns new one.
REQ-036 Counter saturation: preload branch_count to 0xFFFE with valid feedbacks, apply 3 more -> branch_count holds 0xFFFF; rst asserted together with a feedback -> all state at reset values.
